// File: rtl/and_gate_pkg.sv
// Shared types and the per-bit logic function for the mode-selectable AND stage.
package and_gate_pkg;

  typedef enum logic [1:0] {
    MODE_AND  = 2'd0,
    MODE_NAND = 2'd1,
    MODE_ANDN = 2'd2,
    MODE_OFF  = 2'd3
  } and_mode_e;

  function automatic logic and_fn(input logic a, input logic b, input and_mode_e mode);
    logic y;
    case (mode)
      MODE_AND:  y = a & b;
      MODE_NAND: y = ~(a & b);
      MODE_ANDN: y = a & ~b;
      default:   y = 1'b0;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/and_gate_unit_if.sv
// Operand/result bundle for and_gate_unit; master drives operands, slave returns results.
interface and_gate_unit_if #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 8
);

  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [1:0]       mode;
  logic             in_valid;
  logic [WIDTH-1:0] out_y;
  logic             out_valid;
  logic [CNT_W-1:0] hi_count;

  modport master (
    output in_a, in_b, mode, in_valid,
    input  out_y, out_valid, hi_count
  );

  modport slave (
    input  in_a, in_b, mode, in_valid,
    output out_y, out_valid, hi_count
  );

endinterface

// File: rtl/and_pipe_reg.sv
// One pipeline stage: a WIDTH+1-bit register ({valid, data}) with asynchronous clear.
module and_pipe_reg #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH:0]   d,
  output logic [WIDTH:0]   q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= '0;
    else     q <= d;
  end

endmodule

// File: rtl/and_gate_unit.sv
// Registered, mode-selectable bitwise AND with a valid-tagged pipeline and a
// saturating counter of valid all-ones results.
module and_gate_unit
  import and_gate_pkg::*;
#(
  parameter int unsigned WIDTH       = 1,
  parameter int unsigned PIPE_STAGES = 1,
  parameter int unsigned CNT_W       = 8
) (
  input  logic          clk,
  input  logic          rst,
  and_gate_unit_if.slave bus
);

  logic [WIDTH-1:0]                fnY;
  logic [PIPE_STAGES:0][WIDTH:0]   chain;
  logic [CNT_W-1:0]                hiCount;

  always_comb begin
    fnY = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      fnY[i] = and_fn(bus.in_a[i], bus.in_b[i], and_mode_e'(bus.mode));
    end
  end

  // Element 0 is the unregistered stage input; element PIPE_STAGES is the output stage.
  assign chain[0] = {bus.in_valid, fnY};

  for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_pipe
    and_pipe_reg #(.WIDTH(WIDTH)) u_reg (
      .clk (clk),
      .rst (rst),
      .d   (chain[s]),
      .q   (chain[s+1])
    );
  end

  assign bus.out_valid = chain[PIPE_STAGES][WIDTH];
  assign bus.out_y     = chain[PIPE_STAGES][WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hiCount <= '0;
    end else if (bus.out_valid && (&bus.out_y) && (hiCount != '1)) begin
      hiCount <= hiCount + 1'b1;
    end
  end

  assign bus.hi_count = hiCount;

endmodule

// File: tb/tb_and_gate_unit.sv
// Directed self-checking bench for and_gate_unit across three parameter sets.
module tb_and_gate_unit;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  and_gate_unit_if #(.WIDTH(1), .CNT_W(8)) if1 ();
  and_gate_unit_if #(.WIDTH(1), .CNT_W(2)) if3 ();
  and_gate_unit_if #(.WIDTH(8), .CNT_W(8)) if8 ();

  and_gate_unit #(.WIDTH(1), .PIPE_STAGES(1), .CNT_W(8)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
  and_gate_unit #(.WIDTH(1), .PIPE_STAGES(3), .CNT_W(2)) dut3 (.clk(clk), .rst(rst), .bus(if3.slave));
  and_gate_unit #(.WIDTH(8), .PIPE_STAGES(2), .CNT_W(8)) dut8 (.clk(clk), .rst(rst), .bus(if8.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  logic [15:0] sweepExp;
  logic [3:0]  idx;
  int          hiExp [10];
  int          vExp  [10];

  initial begin
    checks = 0;
    errors = 0;
    sweepExp = 16'b0001_0110_0010_0010;
    hiExp = '{0, 0, 0, 0, 0, 1, 2, 3, 3, 3};
    vExp  = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 0};

    rst = 1'b1;
    if1.in_a = '0; if1.in_b = '0; if1.mode = 2'd0; if1.in_valid = 1'b0;
    if3.in_a = '0; if3.in_b = '0; if3.mode = 2'd0; if3.in_valid = 1'b0;
    if8.in_a = '0; if8.in_b = '0; if8.mode = 2'd0; if8.in_valid = 1'b0;
    tick();
    tick();
    check("rst_y1",  32'(if1.out_y), 32'h0);
    check("rst_v1",  32'(if1.out_valid), 32'h0);
    check("rst_hi1", 32'(if1.hi_count), 32'h0);
    check("rst_v3",  32'(if3.out_valid), 32'h0);
    check("rst_hi3", 32'(if3.hi_count), 32'h0);
    check("rst_y8",  32'(if8.out_y), 32'h0);
    check("rst_hi8", 32'(if8.hi_count), 32'h0);
    rst = 1'b0;

    // Exhaustive 1-bit sweep, one vector per cycle, PIPE_STAGES=1
    for (int i = 0; i < 16; i++) begin
      idx = 4'(i);
      if1.in_a = idx[3];
      if1.in_b = idx[2];
      if1.mode = idx[1:0];
      if1.in_valid = 1'b1;
      tick();
      check($sformatf("sweep_y_%0d", i), 32'(if1.out_y), 32'(sweepExp[idx]));
      check($sformatf("sweep_v_%0d", i), 32'(if1.out_valid), 32'h1);
    end
    if1.in_valid = 1'b0;

    // 8-bit operands through a 2-stage pipe, back to back
    if8.in_a = 8'hF0; if8.in_b = 8'h3C; if8.in_valid = 1'b1;
    if8.mode = 2'd0; tick();
    if8.mode = 2'd1; tick();
    check("w8_and",  32'(if8.out_y), 32'h30);
    check("w8_and_v", 32'(if8.out_valid), 32'h1);
    if8.mode = 2'd2; tick();
    check("w8_nand", 32'(if8.out_y), 32'hCF);
    if8.mode = 2'd3; tick();
    check("w8_andn", 32'(if8.out_y), 32'hC0);
    if8.in_valid = 1'b0; tick();
    check("w8_off",   32'(if8.out_y), 32'h00);
    check("w8_off_v", 32'(if8.out_valid), 32'h1);
    tick();
    check("w8_idle_v", 32'(if8.out_valid), 32'h0);
    check("w8_hi",     32'(if8.hi_count), 32'h0);

    // Saturation on CNT_W=2: invalid ones, valid zero, then five valid ones
    for (int t = 0; t < 10; t++) begin
      if3.in_a = 1'b1;
      if3.in_b = 1'b1;
      if3.mode = (t == 1) ? 2'd3 : 2'd0;
      if3.in_valid = (t >= 1 && t <= 6);
      tick();
      check($sformatf("sat_hi_%0d", t + 1), 32'(if3.hi_count), 32'(hiExp[t]));
      check($sformatf("sat_v_%0d", t + 1),  32'(if3.out_valid), 32'(vExp[t]));
    end

    // Single-pulse latency on PIPE_STAGES=3
    if3.in_a = 1'b1; if3.in_b = 1'b1; if3.mode = 2'd0; if3.in_valid = 1'b1;
    tick();
    if3.in_valid = 1'b0;
    check("lat_v_1", 32'(if3.out_valid), 32'h0);
    tick();
    check("lat_v_2", 32'(if3.out_valid), 32'h0);
    tick();
    check("lat_v_3", 32'(if3.out_valid), 32'h1);
    check("lat_y_3", 32'(if3.out_y), 32'h1);
    tick();
    check("lat_v_4", 32'(if3.out_valid), 32'h0);

    // Async reset mid-stream with out_valid=1 and hi_count=2
    if8.in_a = 8'hFF; if8.in_b = 8'hFF; if8.mode = 2'd0; if8.in_valid = 1'b1;
    tick(); tick(); tick(); tick();
    check("pre_rst_v",  32'(if8.out_valid), 32'h1);
    check("pre_rst_y",  32'(if8.out_y), 32'hFF);
    check("pre_rst_hi", 32'(if8.hi_count), 32'h2);
    #2;
    rst = 1'b1;
    #1;
    check("arst_y8",  32'(if8.out_y), 32'h0);
    check("arst_v8",  32'(if8.out_valid), 32'h0);
    check("arst_hi8", 32'(if8.hi_count), 32'h0);
    check("arst_hi3", 32'(if3.hi_count), 32'h0);
    if8.in_valid = 1'b0;
    #1;
    rst = 1'b0;
    tick();
    check("post_rst_v_1",  32'(if8.out_valid), 32'h0);
    tick();
    check("post_rst_v_2",  32'(if8.out_valid), 32'h0);
    check("post_rst_hi_2", 32'(if8.hi_count), 32'h0);
    tick();
    check("post_rst_hi_3", 32'(if8.hi_count), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
